bcd_to_binary: RTL and testbench
================================

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 Parameter: OUT_WIDTH, default 36, width of the binary result; SHALL be >= 30.
REQ-002 Port: Clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: Reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  conversion request; sampled on a rising Clk edge only while idle.
REQ-005 Port: BCD0..BCD8  input  4 each  decimal digits; BCD0 least significant, BCD8 most significant.
REQ-006 Port: data  output  OUT_WIDTH  registered binary result, zero-extended.
REQ-007 Port: busy  output  1  high whenever the block is not in IDLE.
REQ-008 Port: done  output  1  single-cycle completion strobe.
REQ-009 Port: error  output  1  high when the last accepted request held an invalid digit.

Function
REQ-010 The FSM SHALL have three states: IDLE, CONV and DONE.
REQ-011 IDLE, start=1, all digits <= 9: latch BCD0..BCD8 into internal registers, clear the accumulator, set the digit index to 8, clear error, go to CONV.
REQ-012 IDLE, start=1, any digit in 10..15: set error=1, set data=0, go directly to DONE; no CONV cycles.
REQ-013 Digit inputs SHALL be ignored after the capture edge; later changes SHALL NOT affect the result.
REQ-014 Each CONV edge: acc <= acc*10 + digit[index], where acc*10 = (acc<<3)+(acc<<1) in OUT_WIDTH bits; the index then decrements.
REQ-015 The CONV edge that processes index 0 SHALL load data <= final acc and go to DONE; CONV lasts exactly 9 cycles.
REQ-016 DONE SHALL last exactly one cycle, with done=1, then return to IDLE unconditionally.
REQ-017 Latency, valid input: done high in the 10th cycle after the start-sampling edge; back-to-back requests SHALL be accepted every 11 cycles.
REQ-018 Latency, invalid input: done and error high in the cycle right after the start-sampling edge.
REQ-019 start while busy=1 (CONV or DONE) SHALL be ignored, not queued; start held high SHALL be re-sampled once IDLE is re-entered.
REQ-020 data SHALL hold its value from completion until the next completion or reset; it SHALL NOT show intermediate accumulator values.
REQ-021 error SHALL hold from setting until the next accepted start or reset.
REQ-022 Maximum result is 999999999 (0x3B9AC9FF); no overflow is possible for OUT_WIDTH >= 30.
REQ-023 Every output SHALL be driven from registers or from state decode only; no combinational path from inputs to outputs.

Reset
REQ-024 Reset=1 SHALL immediately force, without waiting for Clk: state=IDLE, data=0, busy=0, done=0, error=0, accumulator=0, index=0.
REQ-025 Reset asserted mid-CONV SHALL abort the conversion with no done pulse; the first start after release SHALL begin a fresh conversion.
REQ-026 Reset deasserted with start=1 SHALL accept start on the first Clk edge after release.

Verification
REQ-027 Digits 6,5,0,3,4,5,7,6,8 (BCD8..BCD0), start for one cycle -> busy for 10 cycles, done in cycle 10, data=650345768, error=0.
REQ-028 All digits 9 -> data=999999999; all digits 0 -> data=0; both with done at 10-cycle latency.
REQ-029 BCD3=4'hA, other digits valid -> next cycle done=1, error=1, data=0; no CONV cycles; error clears at the next valid start.
REQ-030 start pulsed again during CONV and digits changed after capture -> no effect; single done; data equals the originally captured value.
REQ-031 Reset asserted at CONV cycle 4 -> all outputs zero immediately, no done; after release a new start gives the correct result with full latency.
REQ-032 start held high continuously with digits 001234593 -> a done every 11 cycles, each with data=1234593.

Source files
------------

// File: rtl/bcd_to_binary.sv
// bcd_to_binary
// Converts a nine-digit BCD number (BCD8 most significant) into a binary
// value using one multiply-by-ten-and-add step per clock.
//
// Ports:
//   Clk          sole clock, rising edge
//   Reset        asynchronous, active-high reset
//   start        conversion request, only looked at while idle
//   BCD0..BCD8   decimal digits, BCD0 least significant
//   data         registered binary result, zero-extended to OUT_WIDTH
//   busy         high whenever the block is converting or signalling done
//   done         one-cycle completion strobe
//   error        last accepted request contained a digit above 9
//
// Timing: a valid request takes 9 CONV cycles plus 1 DONE cycle, so done
// appears in the 10th cycle after the edge that sampled start. A request with
// a bad digit skips CONV and reports done/error in the very next cycle.
module bcd_to_binary #(
  parameter int OUT_WIDTH = 36
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [3:0]           BCD0,
  input  logic [3:0]           BCD1,
  input  logic [3:0]           BCD2,
  input  logic [3:0]           BCD3,
  input  logic [3:0]           BCD4,
  input  logic [3:0]           BCD5,
  input  logic [3:0]           BCD6,
  input  logic [3:0]           BCD7,
  input  logic [3:0]           BCD8,
  output logic [OUT_WIDTH-1:0] data,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [35:0]          digits_q, digits_d;
  logic [3:0]           index_q, index_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic                 error_q, error_d;

  logic [35:0]          digits_in_s;
  logic                 any_invalid_s;
  logic [3:0]           cur_digit_s;
  logic [OUT_WIDTH-1:0] acc_next_s;

  // A BCD nibble is only legal in the range 0..9.
  function automatic logic digit_invalid(input logic [3:0] d);
    return (d > 4'd9);
  endfunction

  // True when any of the nine packed nibbles is out of range.
  function automatic logic any_digit_invalid(input logic [35:0] ds);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 9; i++) begin
      r = r | digit_invalid(ds[i*4 +: 4]);
    end
    return r;
  endfunction

  assign digits_in_s   = {BCD8, BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0};
  assign any_invalid_s = any_digit_invalid(digits_in_s);

  // Select the captured digit currently being folded into the accumulator.
  always_comb begin
    cur_digit_s = 4'd0;
    case (index_q)
      4'd0:    cur_digit_s = digits_q[3:0];
      4'd1:    cur_digit_s = digits_q[7:4];
      4'd2:    cur_digit_s = digits_q[11:8];
      4'd3:    cur_digit_s = digits_q[15:12];
      4'd4:    cur_digit_s = digits_q[19:16];
      4'd5:    cur_digit_s = digits_q[23:20];
      4'd6:    cur_digit_s = digits_q[27:24];
      4'd7:    cur_digit_s = digits_q[31:28];
      4'd8:    cur_digit_s = digits_q[35:32];
      default: cur_digit_s = 4'd0;
    endcase
  end

  // acc*10 built from two shifts so no multiplier is inferred.
  assign acc_next_s = (acc_q << 3'd3) + (acc_q << 3'd1)
                    + {{(OUT_WIDTH-4){1'b0}}, cur_digit_s};

  // Next-state and datapath decisions for the three-state controller.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    index_d  = index_q;
    acc_d    = acc_q;
    data_d   = data_q;
    error_d  = error_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (any_invalid_s) begin
            // Bad request: report immediately, never enter CONV.
            error_d = 1'b1;
            data_d  = {OUT_WIDTH{1'b0}};
            state_d = ST_DONE;
          end else begin
            digits_d = digits_in_s;
            acc_d    = {OUT_WIDTH{1'b0}};
            index_d  = 4'd8;
            error_d  = 1'b0;
            state_d  = ST_CONV;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        acc_d = acc_next_s;
        if (index_q == 4'd0) begin
          // Only the finished value is published on data.
          data_d  = acc_next_s;
          state_d = ST_DONE;
        end else begin
          index_d = index_q - 4'd1;
          state_d = ST_CONV;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      digits_q <= 36'd0;
      index_q  <= 4'd0;
      acc_q    <= {OUT_WIDTH{1'b0}};
      data_q   <= {OUT_WIDTH{1'b0}};
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      index_q  <= index_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      error_q  <= error_d;
    end
  end

  assign data  = data_q;
  assign error = error_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: a cycle-count reference model is
// compared against the DUT outputs on every falling clock edge, and directed
// tasks add literal expectations for the documented examples.
module tb_bcd_to_binary;

  localparam int W = 36;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         start;
  logic [3:0]   bcd [9];
  logic [W-1:0] data;
  logic         busy;
  logic         done;
  logic         error;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_to_binary #(.OUT_WIDTH(W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .start (start),
    .BCD0  (bcd[0]),
    .BCD1  (bcd[1]),
    .BCD2  (bcd[2]),
    .BCD3  (bcd[3]),
    .BCD4  (bcd[4]),
    .BCD5  (bcd[5]),
    .BCD6  (bcd[6]),
    .BCD7  (bcd[7]),
    .BCD8  (bcd[8]),
    .data  (data),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal value of the digit inputs as a weighted sum.
  function automatic logic [63:0] dec_value();
    logic [63:0] v;
    logic [63:0] p;
    v = 64'd0;
    p = 64'd1;
    for (int i = 0; i < 9; i++) begin
      v = v + 64'(bcd[i]) * p;
      p = p * 64'd10;
    end
    return v;
  endfunction

  function automatic bit digits_bad();
    bit b;
    b = 1'b0;
    for (int i = 0; i < 9; i++) if (bcd[i] > 4'd9) b = 1'b1;
    return b;
  endfunction

  task automatic set_digits(input int unsigned v);
    int unsigned t;
    t = v;
    for (int i = 0; i < 9; i++) begin
      bcd[i] = 4'(t % 10);
      t = t / 10;
    end
  endtask

  // Reference model: m_remain counts the busy cycles still to come,
  // the last of which is the done cycle.
  int          m_remain  = 0;
  logic [63:0] m_pending = 64'd0;
  logic [63:0] m_data    = 64'd0;
  bit          m_error   = 1'b0;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_remain  = 0;
      m_pending = 64'd0;
      m_data    = 64'd0;
      m_error   = 1'b0;
    end else if (m_remain == 0) begin
      if (start) begin
        if (digits_bad()) begin
          m_error  = 1'b1;
          m_data   = 64'd0;
          m_remain = 1;
        end else begin
          m_error   = 1'b0;
          m_pending = dec_value();
          m_remain  = 10;
        end
      end
    end else begin
      m_remain--;
      if (m_remain == 1) m_data = m_pending;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge Clk) begin
    chk("model busy",  64'(busy),  64'(m_remain > 0));
    chk("model done",  64'(done),  64'(m_remain == 1));
    chk("model data",  64'(data),  m_data);
    chk("model error", 64'(error), 64'(m_error));
  end

  // One request from idle; optionally disturbs digits and start while busy.
  task automatic do_conv(input string name, input logic [63:0] exp_val, input bit exp_err,
                         input int exp_lat, input bit disturb);
    int n;
    bit seen;
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    n = 1;
    seen = done;
    while (!seen && n < 30) begin
      if (disturb) begin
        for (int i = 0; i < 9; i++) bcd[i] = 4'($urandom_range(0, 15));
        start = 1'($urandom_range(0, 1));
      end
      @(negedge Clk);
      n++;
      seen = done;
    end
    start = 1'b0;
    chk({name, " done seen"}, 64'(seen), 64'd1);
    chk({name, " latency"},   64'(n), 64'(exp_lat));
    chk({name, " data"},      64'(data), exp_val);
    chk({name, " error"},     64'(error), 64'(exp_err));
    @(negedge Clk);
    chk({name, " idle after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int dn;
    int n;
    int last;
    int unsigned v;
    bit bad;
    Reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) bcd[i] = 4'd0;
    repeat (2) @(negedge Clk);
    chk("reset data",  64'(data),  64'd0);
    chk("reset busy",  64'(busy),  64'd0);
    chk("reset done",  64'(done),  64'd0);
    chk("reset error", 64'(error), 64'd0);
    Reset = 1'b0;

    set_digits(650345768);
    do_conv("ex650345768", 64'd650345768, 1'b0, 10, 1'b0);
    set_digits(999999999);
    do_conv("all nines", 64'd999999999, 1'b0, 10, 1'b0);
    set_digits(0);
    do_conv("all zeros", 64'd0, 1'b0, 10, 1'b0);

    set_digits(123456789);
    bcd[3] = 4'hA;
    do_conv("bad digit", 64'd0, 1'b1, 1, 1'b0);
    set_digits(5);
    do_conv("error clears", 64'd5, 1'b0, 10, 1'b0);

    set_digits(650345768);
    do_conv("disturbed", 64'd650345768, 1'b0, 10, 1'b1);

    // Abort in CONV cycle 4 with an asynchronous reset.
    set_digits(987654321);
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (3) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("abort data",  64'(data),  64'd0);
    chk("abort busy",  64'(busy),  64'd0);
    chk("abort done",  64'(done),  64'd0);
    chk("abort error", 64'(error), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    dn = 0;
    repeat (12) begin
      @(negedge Clk);
      if (done) dn++;
    end
    chk("no done after abort", 64'(dn), 64'd0);
    set_digits(123456789);
    do_conv("after abort", 64'd123456789, 1'b0, 10, 1'b0);

    // start already high when reset is released.
    @(negedge Clk);
    Reset = 1'b1;
    set_digits(42);
    start = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("start at release busy", 64'(busy), 64'd1);
    start = 1'b0;
    n = 1;
    while (!done && n < 30) begin
      @(negedge Clk);
      n++;
    end
    chk("start at release latency", 64'(n), 64'd10);
    chk("start at release data", 64'(data), 64'd42);
    @(negedge Clk);

    // start held high: one completion every 11 cycles.
    set_digits(1234593);
    @(negedge Clk);
    start = 1'b1;
    dn = 0;
    last = 0;
    for (int c = 1; c <= 56; c++) begin
      @(negedge Clk);
      if (done) begin
        dn++;
        chk("held data", 64'(data), 64'd1234593);
        if (last == 0) chk("held first latency", 64'(c), 64'd10);
        else chk("held interval", 64'(c - last), 64'd11);
        last = c;
      end
    end
    chk("held done count", 64'(dn), 64'd5);
    start = 1'b0;
    n = 0;
    while (busy && n < 15) begin
      @(negedge Clk);
      n++;
    end
    chk("held drains", 64'(busy), 64'd0);

    // Randomized requests, some with an illegal digit.
    for (int k = 0; k < 20; k++) begin
      v = $urandom_range(0, 999999999);
      set_digits(v);
      if ($urandom_range(0, 3) == 0) bcd[$urandom_range(0, 8)] = 4'($urandom_range(10, 15));
      bad = digits_bad();
      if (bad) do_conv("random bad", 64'd0, 1'b1, 1, 1'($urandom_range(0, 1)));
      else do_conv("random", 64'(v), 1'b0, 10, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
